// File: rtl/scope_frame_rx.sv
// Scope stream frame receiver: length check, ping-pong sample buffer, parameter decode.
// Optional mid-frame idle timeout is enabled by defining SCOPE_RX_TIMEOUT_EN.
module scope_frame_rx #(
  parameter int unsigned P_DATA_LEN  = 1000,
  parameter int unsigned P_PARAM_LEN = 8,
  parameter int unsigned P_TIMEOUT   = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_data_vld,
  input  logic        i_data_last,
  input  logic [9:0]  i_rd_addr,
  input  logic        i_rd_en,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_data_vld,
  output logic        o_buf_ready,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic [31:0] o_user_freq,
  output logic [11:0] o_user_max_val,
  output logic [11:0] o_user_min_val,
  output logic [15:0] o_frame_cnt,
  output logic [7:0]  o_err_cnt
);

  localparam logic [10:0] DATA_LAST  = 11'(P_DATA_LEN - 1);
  localparam logic [10:0] FRAME_LAST = 11'(P_DATA_LEN + P_PARAM_LEN - 1);

  if (P_PARAM_LEN != 8 || P_DATA_LEN > 1024 || P_DATA_LEN < 2 || P_TIMEOUT < 2) begin : g_bad_cfg
    $error("scope_frame_rx: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARAM, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [10:0] cnt, cnt_nxt;
  logic        wr_bank, rd_bank;
  logic        commit, reject, wr_en;
  logic [2:0]  pidx;
  logic [31:0] sh_freq, sh_freq_nxt;
  logic [11:0] sh_max, sh_max_nxt;
  logic [11:0] sh_min, sh_min_nxt;

`ifdef SCOPE_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(P_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(P_TIMEOUT - 1);
  logic [TO_W-1:0] idle_cnt;
  logic            timeout;
  logic            in_frame;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    commit      = 1'b0;
    reject      = 1'b0;
    wr_en       = 1'b0;
    sh_freq_nxt = sh_freq;
    sh_max_nxt  = sh_max;
    sh_min_nxt  = sh_min;
    pidx        = 3'(cnt - 11'(P_DATA_LEN));
`ifdef SCOPE_RX_TIMEOUT_EN
    timeout     = 1'b0;
`endif
    case (state)
      S_IDLE, S_DATA, S_PARAM: begin
        if (i_data_vld) begin
          wr_en = (state != S_PARAM);
          if (state == S_PARAM) begin
            case (pidx)
              3'd0: sh_freq_nxt[31:24] = i_data;
              3'd1: sh_freq_nxt[23:16] = i_data;
              3'd2: sh_freq_nxt[15:8]  = i_data;
              3'd3: sh_freq_nxt[7:0]   = i_data;
              3'd4: sh_max_nxt[11:8]   = i_data[3:0];
              3'd5: sh_max_nxt[7:0]    = i_data;
              3'd6: sh_min_nxt[11:8]   = i_data[3:0];
              default: sh_min_nxt[7:0] = i_data;
            endcase
          end
          if (i_data_last) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            if (cnt == FRAME_LAST) commit = 1'b1;
            else                   reject = 1'b1;
          end else if (cnt == FRAME_LAST) begin
            // Over-length: report once now, swallow the rest silently.
            state_nxt = S_DROP;
            cnt_nxt   = '0;
            reject    = 1'b1;
          end else begin
            cnt_nxt   = cnt + 11'd1;
            state_nxt = (cnt >= DATA_LAST) ? S_PARAM : S_DATA;
          end
        end
`ifdef SCOPE_RX_TIMEOUT_EN
        else if (state != S_IDLE && idle_cnt == TO_LAST) begin
          timeout   = 1'b1;
          reject    = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
`endif
      end
      default: begin
        if (i_data_vld && i_data_last) state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef SCOPE_RX_TIMEOUT_EN
  assign in_frame = (state == S_DATA) || (state == S_PARAM);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_data_vld || timeout || !in_frame) idle_cnt <= '0;
    else                                            idle_cnt <= idle_cnt + 1'b1;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_freq        <= '0;
      sh_max         <= '0;
      sh_min         <= '0;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b1;
      o_frame_done   <= 1'b0;
      o_frame_err    <= 1'b0;
      o_buf_ready    <= 1'b0;
      o_user_freq    <= '0;
      o_user_max_val <= '0;
      o_user_min_val <= '0;
      o_frame_cnt    <= '0;
      o_err_cnt      <= '0;
    end else begin
      sh_freq      <= sh_freq_nxt;
      sh_max       <= sh_max_nxt;
      sh_min       <= sh_min_nxt;
      o_frame_done <= commit;
      o_frame_err  <= reject;
      if (commit) begin
        o_user_freq    <= sh_freq_nxt;
        o_user_max_val <= sh_max_nxt;
        o_user_min_val <= sh_min_nxt;
        wr_bank        <= ~wr_bank;
        o_frame_cnt    <= o_frame_cnt + 16'd1;
        o_buf_ready    <= 1'b1;
      end
      // Readers switch one cycle after the writer, so a read issued during
      // the done pulse still sees the previous frame.
      if (o_frame_done) rd_bank <= ~rd_bank;
      if (reject && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

  logic [7:0] mem [0:2047];
  logic [7:0] ram_q;
  logic       rd_zero;

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[{wr_bank, cnt[9:0]}] <= i_data;
    if (i_rd_en) ram_q <= mem[{rd_bank, i_rd_addr}];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_data_vld <= 1'b0;
      rd_zero       <= 1'b1;
    end else begin
      o_rd_data_vld <= i_rd_en;
      if (i_rd_en) rd_zero <= (32'(i_rd_addr) >= P_DATA_LEN);
    end
  end

  assign o_rd_data = rd_zero ? 8'd0 : ram_q;

endmodule

// File: tb/tb_scope_frame_rx.sv
// Randomized bench for scope_frame_rx against a frame-level reference model.
module tb_scope_frame_rx;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_data_vld;
  logic        i_data_last;
  logic [9:0]  i_rd_addr;
  logic        i_rd_en;
  logic [7:0]  o_rd_data;
  logic        o_rd_data_vld;
  logic        o_buf_ready;
  logic        o_frame_done;
  logic        o_frame_err;
  logic [31:0] o_user_freq;
  logic [11:0] o_user_max_val;
  logic [11:0] o_user_min_val;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_err_cnt;

  scope_frame_rx #(.P_DATA_LEN(1000), .P_PARAM_LEN(8), .P_TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_data_vld(i_data_vld),
    .i_data_last(i_data_last), .i_rd_addr(i_rd_addr), .i_rd_en(i_rd_en),
    .o_rd_data(o_rd_data), .o_rd_data_vld(o_rd_data_vld), .o_buf_ready(o_buf_ready),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err), .o_user_freq(o_user_freq),
    .o_user_max_val(o_user_max_val), .o_user_min_val(o_user_min_val),
    .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  int rd_force = -2;   // -2 reads off, -1 random reads, >=0 fixed address every cycle
  logic [7:0] fb [0:1199];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: frame-level rules on a byte queue.
  logic        exp_done, exp_err, exp_ready, exp_rd_vld, exp_rd_known;
  logic [15:0] exp_fcnt;
  logic [7:0]  exp_ecnt, exp_rd_data;
  logic [31:0] exp_freq;
  logic [11:0] exp_max, exp_min;
  logic [7:0]  m_q [$];
  logic [7:0]  m_rd [0:999];
  logic [7:0]  m_stage [0:999];
  bit          m_drop, m_rd_ok, m_swap;
  int          m_idle;

  function automatic void m_bad();
    exp_err = 1'b1;
    if (exp_ecnt != 8'hFF) exp_ecnt = exp_ecnt + 8'd1;
  endfunction

  function automatic void m_good();
    for (int k = 0; k < 1000; k++) m_stage[k] = m_q[k];
    m_swap    = 1'b1;
    exp_freq  = {m_q[1000], m_q[1001], m_q[1002], m_q[1003]};
    exp_max   = {m_q[1004][3:0], m_q[1005]};
    exp_min   = {m_q[1006][3:0], m_q[1007]};
    exp_done  = 1'b1;
    exp_fcnt  = exp_fcnt + 16'd1;
    exp_ready = 1'b1;
  endfunction

  initial begin
    {exp_done, exp_err, exp_ready, exp_rd_vld, exp_rd_known} = '0;
    exp_fcnt = '0; exp_ecnt = '0; exp_rd_data = '0;
    exp_freq = '0; exp_max = '0; exp_min = '0;
    m_drop = 0; m_rd_ok = 0; m_swap = 0; m_idle = 0;
    forever begin
      @(posedge i_clk);
      if (i_rst) begin
        {exp_done, exp_err, exp_ready, exp_rd_vld} = '0;
        exp_fcnt = '0; exp_ecnt = '0;
        exp_freq = '0; exp_max = '0; exp_min = '0;
        m_q.delete();
        m_drop = 0; m_rd_ok = 0; m_swap = 0; m_idle = 0;
      end else begin
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_rd_vld = i_rd_en;
        if (i_rd_en) begin
          exp_rd_known = m_rd_ok || (i_rd_addr >= 1000);
          exp_rd_data  = (i_rd_addr >= 1000) ? 8'd0 : m_rd[i_rd_addr];
        end
        if (m_swap) begin
          m_rd = m_stage;
          m_rd_ok = 1;
          m_swap = 0;
        end
        if (i_data_vld) begin
          m_idle = 0;
          if (m_drop) begin
            if (i_data_last) m_drop = 0;
          end else begin
            m_q.push_back(i_data);
            if (i_data_last) begin
              if (m_q.size() == 1008) m_good(); else m_bad();
              m_q.delete();
            end else if (m_q.size() == 1008) begin
              m_bad();
              m_q.delete();
              m_drop = 1;
            end
          end
        end
`ifdef SCOPE_RX_TIMEOUT_EN
        else if (!m_drop && m_q.size() > 0) begin
          m_idle++;
          if (m_idle == 16) begin
            m_bad();
            m_q.delete();
            m_idle = 0;
          end
        end
`endif
      end
    end
  end

  initial forever begin
    @(negedge i_clk);
    if (chk_en) begin
      check("frame_done", o_frame_done, exp_done);
      check("frame_err", o_frame_err, exp_err);
      check("frame_cnt", o_frame_cnt, exp_fcnt);
      check("err_cnt", o_err_cnt, exp_ecnt);
      check("buf_ready", o_buf_ready, exp_ready);
      check("user_freq", o_user_freq, exp_freq);
      check("user_max", o_user_max_val, exp_max);
      check("user_min", o_user_min_val, exp_min);
      check("rd_vld", o_rd_data_vld, exp_rd_vld);
      if (exp_rd_vld && exp_rd_known) check("rd_data", o_rd_data, exp_rd_data);
    end
  end

  initial begin
    i_rd_en = 1'b0;
    i_rd_addr = '0;
    forever begin
      @(negedge i_clk);
      if (rd_force == -2) begin
        i_rd_en = 1'b0;
      end else if (rd_force >= 0) begin
        i_rd_en = 1'b1;
        i_rd_addr = 10'(rd_force);
      end else begin
        i_rd_en = 1'($urandom_range(0, 1));
        i_rd_addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023))
                                                : 10'($urandom_range(0, 999));
      end
    end
  end

  task automatic build_frame(input bit plan, input int s0);
    for (int i = 0; i < 1200; i++) begin
      if (plan) fb[i] = (i < 1000) ? 8'(i) : 8'(i - 999);
      else      fb[i] = 8'($urandom);
    end
    if (s0 >= 0) fb[0] = 8'(s0);
  endtask

  task automatic idle_cycle();
    @(negedge i_clk);
    i_data_vld = 1'b0;
    i_data_last = 1'b0;
    i_data = 8'($urandom);
  endtask

  // Returns on the negedge right after the last byte (the done/err cycle).
  task automatic send_frame(input int nbytes, input int last_idx, input int gap_mode,
                            input int stall_at, input int stall_len);
    for (int i = 0; i < nbytes; i++) begin
      if (i == stall_at) repeat (stall_len) idle_cycle();
      if (gap_mode == 1 && i > 0) idle_cycle();
      else if (gap_mode == 2 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) idle_cycle();
      @(negedge i_clk);
      i_data_vld  = 1'b1;
      i_data      = fb[i];
      i_data_last = (i == last_idx);
    end
    @(negedge i_clk);
    i_data_vld  = 1'b0;
    i_data_last = 1'b0;
  endtask

  task automatic read_check(input int addr, input logic [7:0] exp, input string nm);
    @(posedge i_clk);
    rd_force = addr;
    @(negedge i_clk);
    @(negedge i_clk);
    check(nm, o_rd_data, exp);
    check({nm, "_vld"}, o_rd_data_vld, 1'b1);
    rd_force = -1;
  endtask

  initial begin
    int kind, n;
    i_rst = 1'b1;
    i_data = '0;
    i_data_vld = 1'b0;
    i_data_last = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_done", o_frame_done, 0);
    check("rst_err", o_frame_err, 0);
    check("rst_fcnt", o_frame_cnt, 0);
    check("rst_ecnt", o_err_cnt, 0);
    check("rst_ready", o_buf_ready, 0);
    check("rst_freq", o_user_freq, 0);
    check("rst_max", o_user_max_val, 0);
    check("rst_min", o_user_min_val, 0);
    check("rst_rd_vld", o_rd_data_vld, 0);
    check("rst_rd_data", o_rd_data, 0);
    chk_en = 1'b1;
    i_rst = 1'b0;
    rd_force = -1;

    // Contiguous reference frame.
    build_frame(1, -1);
    send_frame(1008, 1007, 0, -1, 0);
    check("good_done", o_frame_done, 1);
    check("good_freq", o_user_freq, 32'h01020304);
    check("good_max", o_user_max_val, 12'h506);
    check("good_min", o_user_min_val, 12'h708);
    check("good_fcnt", o_frame_cnt, 1);
    check("good_ready", o_buf_ready, 1);
    read_check(5, 8'd5, "good_rd5");

    // Same frame with vld toggling.
    send_frame(1008, 1007, 1, -1, 0);
    check("gap_done", o_frame_done, 1);
    check("gap_fcnt", o_frame_cnt, 2);
    check("gap_freq", o_user_freq, 32'h01020304);

    // Short frame.
    build_frame(0, -1);
    send_frame(501, 500, 0, -1, 0);
    check("short_err", o_frame_err, 1);
    check("short_ecnt", o_err_cnt, 1);
    check("short_freq", o_user_freq, 32'h01020304);
    read_check(5, 8'd5, "short_rd5");

    // Long frame followed by a good one.
    send_frame(1100, 1099, 0, -1, 0);
    check("long_ecnt", o_err_cnt, 2);
    build_frame(0, -1);
    send_frame(1008, 1007, 2, -1, 0);
    check("after_long_fcnt", o_frame_cnt, 3);

    // Ping-pong swap timing on address 0.
    @(posedge i_clk);
    rd_force = 0;
    build_frame(0, 8'hAA);
    send_frame(1008, 1007, 0, -1, 0);
    build_frame(0, 8'h55);
    send_frame(1008, 1007, 2, -1, 0);
    check("pp_done", o_frame_done, 1);
    @(negedge i_clk);
    check("pp_done_cycle_rd", o_rd_data, 8'hAA);
    @(negedge i_clk);
    check("pp_next_rd", o_rd_data, 8'h55);
    rd_force = -1;

    // Reset in the middle of a frame.
    build_frame(0, -1);
    send_frame(300, -1, 0, -1, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("midrst_ready", o_buf_ready, 0);
    check("midrst_fcnt", o_frame_cnt, 0);
    check("midrst_err", o_frame_err, 0);

`ifdef SCOPE_RX_TIMEOUT_EN
    send_frame(200, -1, 0, -1, 0);
    repeat (20) idle_cycle();
    check("to_ecnt", o_err_cnt, 1);
    build_frame(0, -1);
    send_frame(1008, 1007, 0, 300, 15);
    check("to_resume_done", o_frame_done, 1);
    check("to_resume_fcnt", o_frame_cnt, 1);
`endif

    // One-byte frames drive the error counter into saturation.
    for (int i = 0; i < 260; i++) send_frame(1, 0, 0, -1, 0);
    check("ecnt_sat", o_err_cnt, 8'hFF);

    // Randomized mix of frame shapes.
    for (int f = 0; f < 8; f++) begin
      build_frame(0, -1);
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1: n = 1008;
        2:    n = $urandom_range(2, 1007);
        3:    n = $urandom_range(1009, 1100);
        default: n = 1;
      endcase
      send_frame(n, n - 1, $urandom_range(0, 2), -1, 0);
      repeat ($urandom_range(0, 4)) idle_cycle();
    end
    repeat (4) @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scope_frame_rx.md
Name: scope_frame_rx

Overview:
- Receive side of the scope display stream: consumes the byte frame of P_DATA_LEN 8-bit samples followed by P_PARAM_LEN parameter bytes.
- Checks frame length, stores samples into a ping-pong sample buffer, and decodes the parameter bytes into frequency/max/min registers.
- Sits between the stream link and the display/readout logic, which reads the last good frame through a random-access read port while the next frame is being received.

Parameters:
- P_DATA_LEN, 1000, sample bytes per frame.
- P_PARAM_LEN, 8, parameter bytes per frame; the decode below is defined for 8 only.
- P_TIMEOUT, 4096, idle cycles allowed mid-frame before abort; used only with SCOPE_RX_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_data  in  8  stream byte
- i_data_vld  in  1  byte qualifier; gaps allowed
- i_data_last  in  1  marks final byte; ignored unless i_data_vld
- i_rd_addr  in  10  sample index 0..P_DATA_LEN-1
- i_rd_en  in  1  read strobe
- o_rd_data  out  8  sample at i_rd_addr from the readable bank
- o_rd_data_vld  out  1  read data valid
- o_buf_ready  out  1  level; at least one good frame stored
- o_frame_done  out  1  1-cycle pulse; good frame committed
- o_frame_err  out  1  1-cycle pulse; frame rejected
- o_user_freq  out  32  decoded frequency
- o_user_max_val  out  12  decoded max (offset-binary)
- o_user_min_val  out  12  decoded min (offset-binary)
- o_frame_cnt  out  16  good frames, wraps
- o_err_cnt  out  8  rejected frames, saturates at 255

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, write bank 0, readable bank 1, shadow parameter registers 0.
- An accepted byte is one with i_data_vld=1. The byte counter increments per accepted byte.
- States:
  - IDLE: the first accepted byte moves to DATA with counter=1 and is written to address 0.
  - DATA: bytes 0..P_DATA_LEN-1 are written to the write bank at address=counter. Moves to PARAM after byte P_DATA_LEN-1.
  - PARAM: parameter bytes go to shadow registers. Byte 0..3 are freq[31:24], [23:16], [15:8], [7:0]. Byte 4 low nibble is max[11:8]; byte 5 is max[7:0]. Byte 6 low nibble is min[11:8]; byte 7 is min[7:0]. Upper nibbles of bytes 4 and 6 are ignored.
  - DROP: discards bytes until an accepted byte with last=1, then returns to IDLE.
- Good frame: last=1 on accepted byte index P_DATA_LEN+P_PARAM_LEN-1 (1007).
  - Next cycle: shadow registers are copied to the o_user_* outputs, the banks swap, o_frame_done pulses, o_frame_cnt increments, o_buf_ready is set, state goes to IDLE.
- Short frame: last=1 on an earlier index → o_frame_err pulse, o_err_cnt increments, state IDLE. Outputs and banks are unchanged; the write bank is overwritten by the next frame.
- Long frame: index 1007 accepted without last → error pulse, counter increment, state DROP. Exactly one error is reported per frame.
- A 1-byte frame (last on the first byte) is a short-frame error.
- Read port: o_rd_data and o_rd_data_vld are registered, 1-cycle latency after i_rd_en.
  - Reads always use the readable bank.
  - A read issued on the same cycle as the o_frame_done pulse returns the pre-swap bank; reads from the next cycle return the new frame.
  - Address ≥ P_DATA_LEN returns 0, with vld still asserted.
  - Reads while o_buf_ready=0 return undefined data; vld still asserts.
- Reset mid-frame: frame abandoned, no error pulse, all counters and o_buf_ready cleared.
- Buffer is inferable block RAM: two banks of 1024×8, one write port, one registered read port.

Optional Feature:
- Macro: SCOPE_RX_TIMEOUT_EN.
- Defined: an idle counter runs in DATA/PARAM, counting consecutive cycles without an accepted byte and clearing on each accepted byte.
  - Reaching P_TIMEOUT aborts the frame: o_frame_err pulse, o_err_cnt increments, state IDLE.
  - DROP is never timed out.
- Undefined: no idle counter; the block waits indefinitely mid-frame.

Test Plan:
- Good frame: send 1008 contiguous bytes (samples i%256, params 1..8, last on 1007) → one o_frame_done, freq=0x01020304, max=0x506, min=0x708, frame_cnt=1, buf_ready=1; reading addr 5 returns 5 one cycle later.
- Gapped good frame: same frame with vld toggled 1-0 → identical results; frame_done occurs 1 cycle after the last accepted byte.
- Short frame: last on byte 500 after a prior good frame → one err pulse, err_cnt=1, outputs and read data still from the prior frame.
- Long frame: 1100 bytes with last on 1099, then a good frame → one err pulse at byte 1007; the next frame is accepted, frame_cnt increments.
- Ping-pong: a continuous read loop on addr 0 across two good frames (sample0 = 0xAA then 0x55) → data changes exactly on the cycle after the frame_done pulse; the rd_en issued on the done cycle still returns 0xAA; reset at byte 300 clears buf_ready and frame_cnt.
- With SCOPE_RX_TIMEOUT_EN and P_TIMEOUT=16: stall 16 cycles at byte 200 → err pulse, state IDLE; a stall of 15 cycles then resume → good frame.
